comb_seq_ctrl: RTL and testbench

//   Sequencer for the 4-operand compare/add datapath. Collects four DATA_W-bit

---
 rtl/comb_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_comb_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_seq_ctrl.sv
// Four-operand serial collector feeding the compare/add datapath.
// Optional out_ready back-pressure enabled by COMB_SEQ_OUT_READY_EN.
module comb_seq_ctrl #(
  parameter int DATA_W  = 7,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_num,
`ifdef COMB_SEQ_OUT_READY_EN
  input  logic              out_ready,
`endif
  output logic              in_ready,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W:0]   out_num0,
  output logic [DATA_W:0]   out_num1,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [DATA_W-1:0] ops [4];
  logic [1:0]        idx;
  logic [7:0]        gap;

  logic [DATA_W-1:0] x, o, a, y;
  logic [DATA_W-1:0] l1, s1, l2, s2;
  logic [DATA_W:0]   sum_l, sum_s, gray_s;

  always_comb begin
    x = ops[0] ~^ ops[1];
    o = ops[1] | ops[3];
    a = ops[0] & ops[2];
    y = ops[2] ^ ops[3];
    l1 = o;
    s1 = x;
    if (x >= o) begin
      l1 = x;
      s1 = o;
    end
    l2 = y;
    s2 = a;
    if (a >= y) begin
      l2 = a;
      s2 = y;
    end
    sum_l  = {1'b0, l1} + {1'b0, l2};
    sum_s  = {1'b0, s1} + {1'b0, s2};
    gray_s = sum_s ^ (sum_s >> 1);
  end

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      for (int i = 0; i < 4; i++) ops[i] <= '0;
      idx      <= '0;
      gap      <= '0;
      out_num0 <= '0;
      out_num1 <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ops[0] <= in_num;
            idx    <= 2'd1;
            gap    <= '0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            ops[idx] <= in_num;
            idx      <= idx + 2'd1;
            gap      <= '0;
            if (idx == 2'd3) state <= CALC;
          end else if (gap == GAP_LAST) begin
            // abort: the err cycle is already an IDLE cycle
            err   <= 1'b1;
            for (int i = 0; i < 4; i++) ops[i] <= '0;
            idx   <= '0;
            gap   <= '0;
            state <= IDLE;
          end else begin
            gap <= gap + 8'd1;
          end
        end
        CALC: begin
          out_num0 <= sum_l;
          out_num1 <= gray_s;
          state    <= OUT;
        end
        OUT: begin
`ifdef COMB_SEQ_OUT_READY_EN
          if (out_ready) state <= IDLE;
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_seq_ctrl.sv
// Scoreboard bench for comb_seq_ctrl: expected results queued per frame,
// popped on each out_valid cycle.
module tb_comb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] in_num;
  logic       out_ready;
  logic       in_ready, busy, out_valid, err;
  logic [7:0] out_num0, out_num1;

  int n_chk = 0;
  int n_fail = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  comb_seq_ctrl #(.DATA_W(7), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_num(in_num),
`ifdef COMB_SEQ_OUT_READY_EN
    .out_ready(out_ready),
`endif
    .in_ready(in_ready),
    .busy(busy),
    .out_valid(out_valid),
    .out_num0(out_num0),
    .out_num1(out_num1),
    .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [6:0] p0, p1, p2, p3);
    logic [6:0] tx, to, ta, ty, big1, sml1, big2, sml2;
    logic [7:0] r0, s;
    tx = ~(p0 ^ p1);
    to = p1 | p3;
    ta = p0 & p2;
    ty = p2 ^ p3;
    big1 = (tx >= to) ? tx : to;
    sml1 = (tx >= to) ? to : tx;
    big2 = (ta >= ty) ? ta : ty;
    sml2 = (ta >= ty) ? ty : ta;
    r0 = 8'(big1) + 8'(big2);
    s = 8'(sml1) + 8'(sml2);
    return {r0, s ^ {1'b0, s[7:1]}};
  endfunction

  always @(negedge clk) begin
    if (err) n_err++;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("out_num0", out_num0, e[15:8]);
        check("out_num1", out_num1, e[7:0]);
      end
`ifdef COMB_SEQ_OUT_READY_EN
      if (!out_ready) exp_q.push_front(e_hold(out_num0, out_num1));
`endif
    end
  end

  function automatic logic [15:0] e_hold(input logic [7:0] a, b);
    return {a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] v);
    in_valid = 1'b1;
    in_num = v;
    tick();
    in_valid = 1'b0;
  endtask

  // sends a whole frame; returns one step after the op3 edge (CALC cycle)
  task automatic frame(input logic [6:0] p0, p1, p2, p3);
    exp_q.push_back(model(p0, p1, p2, p3));
    put(p0);
    put(p1);
    put(p2);
    put(p3);
  endtask

  task automatic finish_frame();
    check("calc_out_valid", out_valid, 0);
    check("calc_in_ready", in_ready, 0);
    tick();
    check("out_valid_t2", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("idle_after_out", in_ready, 1);
    check("pulse_end", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_num = '0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_num0", out_num0, 0);
    check("rst_out_num1", out_num1, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    frame(0, 0, 0, 0);
    finish_frame();
    frame(1, 2, 3, 4);
    finish_frame();
    frame(127, 127, 127, 127);
    finish_frame();

    // timeout abort after two operands
    e0 = n_err;
    put(5);
    put(9);
    repeat (14) tick();
    check("no_err_at_14", err, 0);
    tick();
    check("err_pulse", err, 1);
    check("err_idle", busy, 0);
    tick();
    check("err_one_cycle", err, 0);
    check("err_count", n_err - e0, 1);
    frame(1, 2, 3, 4);
    finish_frame();

    // 14-cycle gap is tolerated
    e0 = n_err;
    exp_q.push_back(model(10, 20, 30, 40));
    put(10);
    put(20);
    put(30);
    repeat (14) tick();
    check("gap14_busy", busy, 1);
    put(40);
    finish_frame();
    check("gap14_no_err", n_err - e0, 0);

    // in_valid held high through CALC/OUT
    exp_q.push_back(model(3, 6, 9, 12));
    put(3);
    put(6);
    put(9);
    in_valid = 1'b1;
    in_num = 12;
    tick();
    in_num = 99;
    check("hold_calc_ready", in_ready, 0);
    tick();
    check("hold_out_ready", in_ready, 0);
    check("hold_out_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check("hold_idle", busy, 0);

    // random frames with short gaps
    for (int k = 0; k < 6; k++) begin
      logic [6:0] r [4];
      for (int j = 0; j < 4; j++) r[j] = 7'($urandom_range(0, 127));
      exp_q.push_back(model(r[0], r[1], r[2], r[3]));
      for (int j = 0; j < 4; j++) begin
        put(r[j]);
        if (j < 3) repeat ($urandom_range(0, 3)) tick();
      end
      finish_frame();
    end

    // reset in the middle of a frame
    put(7);
    put(8);
    put(9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_num0", out_num0, 0);
    check("mid_rst_out_num1", out_num1, 0);
    check("mid_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    frame(1, 2, 3, 4);
    finish_frame();

`ifdef COMB_SEQ_OUT_READY_EN
    exp_q.push_back(model(2, 4, 6, 8));
    put(2);
    put(4);
    put(6);
    out_ready = 1'b0;
    put(8);
    tick();
    repeat (4) begin
      tick();
      check("held_valid", out_valid, 1);
      check("held_num0", out_num0, model(2, 4, 6, 8) >> 8);
    end
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    tick();
    tick();
    check("released", out_valid, 0);
`endif

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
